sdram_arbmod: RTL and testbench
===============================

# sdram_arbmod

Two-client arbiter that shares one `sdram_basemod` instance between two requesters, such as a camera writer and a display reader. It accepts write/read calls from client 0 and client 1 and serialises them onto the single `iCall`/`iAddr` port of the SDRAM base module. It returns each completion to the originating client and exposes a one-hot grant so the top level can steer the FIFO data/enable lines. A watchdog aborts any call that the SDRAM side never completes.

## Interface
- `AW`, 24, address width; matches `sdram_basemod` `iAddr`.
- `TIMEOUT`, 4096, maximum cycles to wait for downstream done; 0 disables the watchdog.

- `CLOCK`  in  1  system clock; all logic rising-edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `iCall0`  in  2  client 0 call, [1]=write, [0]=read; level, held until done.
- `iAddr0`  in  AW  client 0 address, stable while `iCall0`≠0.
- `oDone0`  out  2  client 0 done pulse, bit matches the served operation.
- `iCall1`, `iAddr1`, `oDone1`  same as above for client 1.
- `oCall`  out  2  to `sdram_basemod.iCall`, [1]=write, [0]=read.
- `oAddr`  out  AW  to `sdram_basemod.iAddr`.
- `iDone`  in  2  from `sdram_basemod.oDone`, one-cycle pulse.
- `oGrant`  out  2  one-hot owner, [0]=client 0, [1]=client 1; 0 when idle.
- `oErr`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, CALL, DONE.
- IDLE:
  - A client is pending when its `iCall`≠0.
  - With one client pending, it wins.
  - With both pending, the client that is not `last` wins (round-robin).
  - `last` resets to 1, so client 0 wins the first tie.
  - The winner's operation is latched: write if `iCall[1]`=1, otherwise read. Write beats read when a client sets both bits; its read remains pending and is served on a later grant.
  - Address, grant and operation are registered; go to CALL.
- CALL:
  - `oCall` drives the latched operation bit, `oAddr` the latched address, `oGrant` the winner.
  - Only the `iDone` bit matching the latched operation completes the call; the other bit is ignored.
  - On a matching done: go to DONE.
  - Watchdog (`TIMEOUT`≠0): a 16-bit counter increments each CALL cycle. When it reaches `TIMEOUT`-1 without a matching done, `oErr`=1 for one cycle and the state goes to DONE (abort).
- DONE:
  - `oCall`=0.
  - The winner's `oDone` bit for the latched operation = 1 for exactly one cycle; this happens on aborts too.
  - `last` ← winner; `oGrant` ← 0.
  - Go to IDLE.
- Clients must drop the completed `iCall` bit in the cycle following their done pulse. IDLE therefore does not re-grant a stale call, because the arbiter spends one IDLE cycle before sampling requests.
- `iAddr` and `iCall` changes during CALL have no effect, because the values are latched.
- Reset (async, any state):
  - State = IDLE, `last`=1, counter=0.
  - `oCall`=0, `oAddr`=0, `oGrant`=0, `oDone0`=`oDone1`=0, `oErr`=0.
  - An in-flight call is dropped without a done pulse.
- `iDone` arriving in IDLE or DONE is ignored.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request sampled in IDLE at cycle t:
  - `oCall`, `oAddr`, `oGrant` valid at t+1.
- Matching `iDone` sampled at cycle c:
  - `oCall`=0 and `oDone`=1 at c+1.
  - IDLE at c+2.
  - Next `oCall` no earlier than c+3.
- Minimum per-transaction overhead: 3 cycles beyond the SDRAM latency.
- Watchdog abort occurs exactly `TIMEOUT` cycles after `oCall` rises: `oErr` and `oDone` are high together in the DONE cycle, and `oCall` falls in that cycle.
- `oGrant` is high from the first CALL cycle up to and including the DONE cycle. The top level uses it to mux `iEn`/`iData` and to route `oData`.

## Test plan
- **Single write:** `iCall0`=2'b10, `iAddr0`=24'h000100; `iDone`=2'b10 after 10 cycles.
  - Required: `oCall`=2'b10, `oAddr`=24'h000100, `oGrant`=2'b01 from t+1.
  - Required: `oDone0`=2'b10 for one cycle; `oDone1` stays 0.
- **Simultaneous requests:** client 0 write and client 1 read asserted in the same cycle after reset.
  - Required: client 0 served first, then client 1.
  - Repeat both with clients re-requesting: the order alternates 1, 0, 1 …
- **Both bits from one client:** `iCall1`=2'b11.
  - Required: the write is served first (`oCall`=2'b10).
  - Required: after `oDone1`=2'b10 and the client lowering bit 1, the read is served (`oCall`=2'b01).
- **Wrong done bit:** a read in flight receives `iDone`=2'b10.
  - Required: ignored; `oCall` stays 2'b01 until `iDone`=2'b01.
- **Watchdog:** `TIMEOUT`=16, `iDone` never asserted.
  - Required: `oErr`=1 and `oDone0`=2'b01 in the same cycle, 16 cycles after `oCall` rose; the arbiter then returns to IDLE.
- **Reset mid-CALL:** `RESET` pulsed during CALL.
  - Required: all outputs 0 asynchronously and no done pulse.
  - Required: after release, a fresh tie grants client 0.

Source files
------------

// File: rtl/sdram_arbmod.sv
// Two-client arbiter in front of a single sdram_basemod instance.
// Serialises client write/read calls onto one iCall/iAddr port, routes the
// completion back to the originating client, exposes a one-hot grant for
// steering the data path, and aborts calls the SDRAM side never finishes.
module sdram_arbmod #(
    parameter int unsigned AW      = 24,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [1:0]    iCall0,
    input  logic [AW-1:0] iAddr0,
    output logic [1:0]    oDone0,
    input  logic [1:0]    iCall1,
    input  logic [AW-1:0] iAddr1,
    output logic [1:0]    oDone1,
    output logic [1:0]    oCall,
    output logic [AW-1:0] oAddr,
    input  logic [1:0]    iDone,
    output logic [1:0]    oGrant,
    output logic          oErr
);

    localparam int unsigned CW = 16;
    // Watchdog fires on the CALL cycle whose count equals TIMEOUT-1, so the
    // abort lands exactly TIMEOUT cycles after oCall rises.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam bit            WD_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic          last;      // client served most recently (tie breaker)
    logic          winner;    // client owning the current call
    logic [1:0]    op;        // latched operation, one-hot {write, read}
    logic [CW-1:0] wdCnt;

    logic          pend0;
    logic          pend1;
    logic          anyPend;
    logic          pick;
    logic          pickWr;
    logic [1:0]    pickOp;
    logic [AW-1:0] pickAddr;
    logic          doneHit;
    logic          wdHit;

    // Round-robin pick among pending clients and completion/abort detection
    always_comb begin
        pend0    = |iCall0;
        pend1    = |iCall1;
        anyPend  = pend0 | pend1;
        if (pend0 && pend1) begin
            pick = ~last;
        end else begin
            pick = pend1;
        end
        pickWr   = pick ? iCall1[1] : iCall0[1];
        pickOp   = pickWr ? 2'b10 : 2'b01;
        pickAddr = pick ? iAddr1 : iAddr0;
        doneHit  = |(iDone & op);
        wdHit    = WD_EN && (wdCnt == WD_LAST);
    end

    // Arbiter FSM with registered SDRAM-side and client-side outputs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            last   <= 1'b1;
            winner <= 1'b0;
            op     <= 2'b00;
            wdCnt  <= '0;
            oCall  <= 2'b00;
            oAddr  <= '0;
            oGrant <= 2'b00;
            oDone0 <= 2'b00;
            oDone1 <= 2'b00;
            oErr   <= 1'b0;
        end else begin
            oDone0 <= 2'b00;
            oDone1 <= 2'b00;
            oErr   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (anyPend) begin
                        state  <= CALL;
                        winner <= pick;
                        op     <= pickOp;
                        oCall  <= pickOp;
                        oAddr  <= pickAddr;
                        oGrant <= pick ? 2'b10 : 2'b01;
                        wdCnt  <= '0;
                    end
                end
                CALL: begin
                    if (doneHit || wdHit) begin
                        // A real completion in the final watchdog cycle wins over the abort
                        state <= DONE;
                        oCall <= 2'b00;
                        oErr  <= ~doneHit;
                        if (winner) begin
                            oDone1 <= op;
                        end else begin
                            oDone0 <= op;
                        end
                    end else begin
                        wdCnt <= wdCnt + 1'b1;
                    end
                end
                DONE: begin
                    last   <= winner;
                    oGrant <= 2'b00;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbmod.sv
// Randomised scoreboard bench for sdram_arbmod with a queue-based
// round-robin reference model and a latency-driven SDRAM responder.
module tb_sdram_arbmod;

    localparam int AW = 24;
    localparam int TO = 16;
    localparam int NEVER = 255;

    logic          CLOCK;
    logic          RESET;
    logic [1:0]    iCall0;
    logic [AW-1:0] iAddr0;
    logic [1:0]    oDone0;
    logic [1:0]    iCall1;
    logic [AW-1:0] iAddr1;
    logic [1:0]    oDone1;
    logic [1:0]    oCall;
    logic [AW-1:0] oAddr;
    logic [1:0]    iDone;
    logic [1:0]    oGrant;
    logic          oErr;

    sdram_arbmod #(.AW(AW), .TIMEOUT(TO)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .iCall0(iCall0),
        .iAddr0(iAddr0),
        .oDone0(oDone0),
        .iCall1(iCall1),
        .iAddr1(iAddr1),
        .oDone1(oDone1),
        .oCall (oCall),
        .oAddr (oAddr),
        .iDone (iDone),
        .oGrant(oGrant),
        .oErr  (oErr)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int            cl;
        logic [1:0]    op;
        logic [AW-1:0] addr;
    } grant_t;

    typedef struct {
        int         cl;
        logic [1:0] op;
        bit         err;
        int         lat;
    } done_t;

    typedef struct {
        logic [1:0] op;
        int         lat;
        int         wrongAt;
        bit         echo;
    } rsp_t;

    grant_t grantQ[$];
    done_t  doneQ[$];
    rsp_t   rspQ[$];

    int total = 0;
    int bad   = 0;
    int mLast = 1;
    bit monEn = 1'b1;
    bit rspEn = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: expand one round of client requests into the served sequence
    task automatic modelRound(input logic [1:0] c0, input logic [AW-1:0] a0,
                              input logic [1:0] c1, input logic [AW-1:0] a1,
                              input int latFix, input int wrongFix);
        logic [1:0] p0;
        logic [1:0] p1;
        logic [1:0] pc;
        logic [1:0] op;
        int w;
        int lat;
        int wr;
        bit echo;
        p0 = c0;
        p1 = c1;
        while (p0 != 2'b00 || p1 != 2'b00) begin
            if (p0 != 2'b00 && p1 != 2'b00) w = (mLast == 1) ? 0 : 1;
            else w = (p0 != 2'b00) ? 0 : 1;
            pc = (w == 0) ? p0 : p1;
            op = pc[1] ? 2'b10 : 2'b01;
            if (latFix >= 0) lat = latFix;
            else if ($urandom_range(0, 7) == 0) lat = NEVER;
            else lat = int'($urandom_range(0, TO - 1));
            wr = -1;
            if (wrongFix >= 0) wr = wrongFix;
            else if (lat > 0 && $urandom_range(0, 2) == 0)
                wr = int'($urandom_range(0, ((lat < TO) ? lat : TO - 1) - 1));
            echo = (latFix < 0) && ($urandom_range(0, 3) == 0);
            grantQ.push_back('{w, op, (w == 0) ? a0 : a1});
            doneQ.push_back('{w, op, lat >= TO, lat});
            rspQ.push_back('{op, lat, wr, echo});
            if (w == 0) p0 = p0 & ~op;
            else p1 = p1 & ~op;
            mLast = w;
        end
    endtask

    // Present a round of requests; clients drop each bit once its done pulse appears
    task automatic runRound(input logic [1:0] c0, input logic [AW-1:0] a0,
                            input logic [1:0] c1, input logic [AW-1:0] a1,
                            input int latFix, input int wrongFix);
        int budget;
        modelRound(c0, a0, c1, a1, latFix, wrongFix);
        iAddr0 = a0;
        iCall0 = c0;
        iAddr1 = a1;
        iCall1 = c1;
        @(negedge CLOCK);
        chk("first_grant_latency", 64'(oCall != 2'b00), 64'(1));
        budget = 200;
        while ((iCall0 | iCall1) != 2'b00 && budget > 0) begin
            @(negedge CLOCK);
            if (oDone0 != 2'b00) iCall0 = iCall0 & ~oDone0;
            if (oDone1 != 2'b00) iCall1 = iCall1 & ~oDone1;
            budget--;
        end
        chk("round_complete", 64'({iCall0, iCall1}), 64'(0));
        iCall0 = 2'b00;
        iCall1 = 2'b00;
        repeat (3) @(negedge CLOCK);
    endtask

    // SDRAM responder: returns the matching done after the planned latency
    initial begin
        rsp_t r;
        int k;
        iDone = 2'b00;
        forever begin
            @(negedge CLOCK);
            if (rspEn && oCall != 2'b00 && rspQ.size() != 0) begin
                r = rspQ.pop_front();
                k = 0;
                while (k < r.lat && oCall != 2'b00) begin
                    iDone = (k == r.wrongAt) ? ~r.op : 2'b00;
                    @(negedge CLOCK);
                    k++;
                end
                if (r.lat < TO) begin
                    iDone = r.op;
                    @(negedge CLOCK);
                    iDone = r.echo ? r.op : 2'b00;
                    if (r.echo) begin
                        @(negedge CLOCK);
                        iDone = 2'b00;
                    end
                end else begin
                    iDone = 2'b00;
                end
            end
        end
    end

    // Monitor: pops expected grants and completions as the DUT presents them
    int         cyc = 0;
    int         callCyc = 0;
    int         doneCyc = 0;
    bit         haveDone = 1'b0;
    logic [1:0] prevCall = 2'b00;
    logic [1:0] heldCall = 2'b00;
    logic [AW-1:0] heldAddr = '0;
    grant_t     g;
    done_t      d;

    initial begin
        forever begin
            @(negedge CLOCK);
            cyc++;
            if (monEn) begin
                if (haveDone && cyc == doneCyc + 1)
                    chk("grant_cleared", 64'(oGrant), 64'(0));
                if (oCall != 2'b00 && prevCall == 2'b00) begin
                    if (grantQ.size() == 0) begin
                        chk("spurious_call", 64'(oCall), 64'(0));
                    end else begin
                        g = grantQ.pop_front();
                        chk("grant_call", 64'(oCall), 64'(g.op));
                        chk("grant_addr", 64'(oAddr), 64'(g.addr));
                        chk("grant_onehot", 64'(oGrant), 64'((g.cl == 1) ? 2'b10 : 2'b01));
                        if (haveDone) chk("grant_gap", 64'((cyc - doneCyc) >= 2), 64'(1));
                        callCyc  = cyc;
                        heldCall = g.op;
                        heldAddr = g.addr;
                    end
                end else if (oCall != 2'b00) begin
                    chk("call_stable", 64'({oCall, oAddr}), 64'({heldCall, heldAddr}));
                end
                if (oDone0 != 2'b00 || oDone1 != 2'b00 || oErr) begin
                    if (doneQ.size() == 0) begin
                        chk("spurious_done", 64'({oDone0, oDone1, oErr}), 64'(0));
                    end else begin
                        d = doneQ.pop_front();
                        chk("done0", 64'(oDone0), 64'((d.cl == 0) ? d.op : 2'b00));
                        chk("done1", 64'(oDone1), 64'((d.cl == 1) ? d.op : 2'b00));
                        chk("err", 64'(oErr), 64'(d.err));
                        chk("done_latency", 64'(cyc - callCyc), 64'(d.err ? TO : d.lat + 1));
                        chk("done_call_low", 64'(oCall), 64'(0));
                        chk("done_grant", 64'(oGrant), 64'((d.cl == 1) ? 2'b10 : 2'b01));
                        doneCyc  = cyc;
                        haveDone = 1'b1;
                    end
                end
            end
            prevCall = oCall;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // Stimulus: directed scenarios, random rounds, then reset mid-call
    initial begin
        logic [1:0] c0;
        logic [1:0] c1;
        RESET  = 1'b1;
        iCall0 = 2'b00;
        iCall1 = 2'b00;
        iAddr0 = '0;
        iAddr1 = '0;
        repeat (3) @(negedge CLOCK);
        chk("rst_call", 64'(oCall), 64'(0));
        chk("rst_addr", 64'(oAddr), 64'(0));
        chk("rst_grant", 64'(oGrant), 64'(0));
        chk("rst_done0", 64'(oDone0), 64'(0));
        chk("rst_done1", 64'(oDone1), 64'(0));
        chk("rst_err", 64'(oErr), 64'(0));
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);

        runRound(2'b10, 24'h000100, 2'b00, 24'h0, 10, -1);
        runRound(2'b10, 24'h000200, 2'b01, 24'h000300, 4, -1);
        runRound(2'b10, 24'h000210, 2'b01, 24'h000310, 5, -1);
        runRound(2'b10, 24'h000220, 2'b01, 24'h000320, 3, -1);
        runRound(2'b00, 24'h0, 2'b11, 24'h00ABCD, 6, -1);
        runRound(2'b00, 24'h0, 2'b01, 24'h001234, 8, 3);
        runRound(2'b01, 24'h00BEEF, 2'b00, 24'h0, NEVER, -1);
        runRound(2'b10, 24'h000777, 2'b00, 24'h0, TO - 1, -1);

        for (int n = 0; n < 40; n++) begin
            c0 = 2'($urandom_range(0, 3));
            c1 = 2'($urandom_range(0, 3));
            if (c0 == 2'b00 && c1 == 2'b00) c1 = 2'b10;
            runRound(c0, AW'($urandom), c1, AW'($urandom), -1, -1);
        end

        // Reset while a call is in flight
        monEn  = 1'b0;
        rspEn  = 1'b0;
        iAddr0 = 24'h00F00D;
        iCall0 = 2'b10;
        for (int i = 0; i < 10 && oCall == 2'b00; i++) @(negedge CLOCK);
        chk("pre_reset_call", 64'(oCall), 64'(2'b10));
        repeat (3) @(negedge CLOCK);
        #2 RESET = 1'b1;
        #1;
        chk("arst_call", 64'(oCall), 64'(0));
        chk("arst_addr", 64'(oAddr), 64'(0));
        chk("arst_grant", 64'(oGrant), 64'(0));
        chk("arst_done0", 64'(oDone0), 64'(0));
        chk("arst_done1", 64'(oDone1), 64'(0));
        chk("arst_err", 64'(oErr), 64'(0));
        iCall0 = 2'b00;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        grantQ.delete();
        doneQ.delete();
        rspQ.delete();
        mLast    = 1;
        haveDone = 1'b0;
        @(negedge CLOCK);
        chk("post_reset_no_done", 64'({oDone0, oDone1}), 64'(0));
        monEn = 1'b1;
        rspEn = 1'b1;
        runRound(2'b01, 24'h000ACE, 2'b10, 24'h000BAD, 2, -1);

        chk("grant_queue_drained", 64'(grantQ.size()), 64'(0));
        chk("done_queue_drained", 64'(doneQ.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
